// File: rtl/bbc_clk_pkg.sv
// rtl/bbc_clk_pkg.sv - shared constants and state encoding for the BBC CPU clock-enable generator
package bbc_clk_pkg;

    localparam int DIV_DEFAULT = 8;

    // Slow (1MHz) I/O windows, inclusive bounds
    localparam logic [15:0] SLOW_FRED_BASE  = 16'hFC00;
    localparam logic [15:0] SLOW_FRED_LIMIT = 16'hFDFF;
    localparam logic [15:0] SLOW_CRTC_BASE  = 16'hFE00;
    localparam logic [15:0] SLOW_CRTC_LIMIT = 16'hFE1F;
    localparam logic [15:0] SLOW_VIA_BASE   = 16'hFE40;
    localparam logic [15:0] SLOW_VIA_LIMIT  = 16'hFE7F;
    localparam logic [15:0] SLOW_ADC_BASE   = 16'hFEC0;
    localparam logic [15:0] SLOW_ADC_LIMIT  = 16'hFEDF;

    localparam logic [1:0] K_MAX = 2'd3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_STRETCH = 1'b1
    } state_e;

endpackage

// File: rtl/cpu_clken_gen_if.sv
// rtl/cpu_clken_gen_if.sv - CPU address in, clock-enable strobes and stretch status out
interface cpu_clken_gen_if;
    logic [15:0] Address_bus;
    logic        cpu_clk_en;
    logic        mhz1_en;
    logic        mhz1_phase;
    logic        slow_cycle;

    modport master (
        output Address_bus,
        input  cpu_clk_en,
        input  mhz1_en,
        input  mhz1_phase,
        input  slow_cycle
    );

    modport slave (
        input  Address_bus,
        output cpu_clk_en,
        output mhz1_en,
        output mhz1_phase,
        output slow_cycle
    );
endinterface

// File: rtl/bbc_slow_decode.sv
// rtl/bbc_slow_decode.sv - combinational decode of addresses that must run at 1MHz
module bbc_slow_decode
    import bbc_clk_pkg::*;
(
    input  logic [15:0] Address_bus,
    output logic        is_slow
);

    assign is_slow = ((Address_bus >= SLOW_FRED_BASE) && (Address_bus <= SLOW_FRED_LIMIT))
                  || ((Address_bus >= SLOW_CRTC_BASE) && (Address_bus <= SLOW_CRTC_LIMIT))
                  || ((Address_bus >= SLOW_VIA_BASE)  && (Address_bus <= SLOW_VIA_LIMIT))
                  || ((Address_bus >= SLOW_ADC_BASE)  && (Address_bus <= SLOW_ADC_LIMIT));

endmodule

// File: rtl/cpu_clken_gen.sv
// rtl/cpu_clken_gen.sv - 2MHz CPU enable with 1MHz cycle stretching for slow I/O accesses
module cpu_clken_gen
    import bbc_clk_pkg::*;
#(
    parameter int DIV        = DIV_DEFAULT,
    parameter int DECODE_CNT = 1
) (
    input  logic            clk,
    input  logic            nRESET,
    cpu_clken_gen_if.slave  bus
);

    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_DEC  = CW'(DECODE_CNT);

    logic [CW-1:0] cnt;
    logic          p;
    state_e        state, state_d;
    logic [1:0]    k, k_d, k_inc;
    logic          boundary, is_slow, stretch_done;
    logic          cpu_en_d, cpu_en_q, m1_d, m1_q;

    bbc_slow_decode u_slow_decode (
        .Address_bus (bus.Address_bus),
        .is_slow     (is_slow)
    );

    assign boundary     = (cnt == CNT_LAST);
    assign k_inc        = (k == K_MAX) ? K_MAX : k + 2'd1;
    // Release only on a 1MHz edge, and never before a full 1MHz period has elapsed
    assign stretch_done = boundary && (k_inc >= 2'd2) && p;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            cnt      <= '0;
            p        <= 1'b0;
            state    <= ST_IDLE;
            k        <= 2'd0;
            cpu_en_q <= 1'b0;
            m1_q     <= 1'b0;
        end else begin
            cnt      <= boundary ? '0 : cnt + 1'b1;
            if (boundary) p <= ~p;
            state    <= state_d;
            k        <= k_d;
            cpu_en_q <= cpu_en_d;
            m1_q     <= m1_d;
        end
    end

    always_comb begin
        state_d = state;
        k_d     = k;
        case (state)
            ST_IDLE: begin
                if ((cnt == CNT_DEC) && is_slow) begin
                    state_d = ST_STRETCH;
                    k_d     = 2'd0;
                end
            end
            ST_STRETCH: begin
                if (boundary) begin
                    k_d = k_inc;
                    if (stretch_done) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m1_d     = boundary && p;
        cpu_en_d = 1'b0;
        case (state)
            ST_IDLE:    cpu_en_d = boundary;
            ST_STRETCH: cpu_en_d = stretch_done;
            default:    cpu_en_d = 1'b0;
        endcase
    end

    assign bus.cpu_clk_en = cpu_en_q;
    assign bus.mhz1_en    = m1_q;
    assign bus.mhz1_phase = p;
    assign bus.slow_cycle = (state == ST_STRETCH);

endmodule

// File: tb/tb_cpu_clken_gen.sv
// tb/tb_cpu_clken_gen.sv - self-checking bench for cpu_clken_gen against a cycle-length model
module tb_cpu_clken_gen;

    localparam int DIV = 8;
    localparam int DC  = 1;

    logic clk;
    logic nRESET;
    cpu_clken_gen_if bus ();

    cpu_clken_gen #(.DIV(DIV), .DECODE_CNT(DC)) u_dut (
        .clk    (clk),
        .nRESET (nRESET),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared;
    int mismatched;

    // Model: a CPU cycle starts at period s; its length follows from the address
    // sampled at s+DC and the 1MHz phase during its first 2MHz period.
    int       t, s, len;
    bit       dec, cur_slow, chg;
    bit [15:0] cur_addr;
    int       q[$];
    logic [3:0] obs, expv;

    function automatic bit ref_slow(input bit [15:0] a);
        return a inside {[16'hFC00:16'hFE1F], [16'hFE40:16'hFE7F], [16'hFEC0:16'hFEDF]};
    endfunction

    function automatic int rand_addr();
        int r;
        r = $urandom_range(0, 3);
        case (r)
            0:       return int'($urandom & 32'hFFFF);
            1:       return 16'hFC00 + $urandom_range(0, 16'h021F);
            2:       return 16'hFE00 + $urandom_range(0, 255) + (int'($urandom_range(0, 1)) << 16);
            default: return 16'h1234;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nRESET = 1'b1;
        t = 0; s = 0; len = DIV; dec = 0; cur_slow = 0; chg = 0;
        q.delete();
    endtask

    task automatic model_period();
        int v;
        if (dec && t == s + len) begin
            s   = t;
            dec = 0;
        end
        if (t == s) begin
            v = (q.size() > 0) ? q.pop_front() : rand_addr();
            cur_addr = v[15:0];
            chg      = v[16];
            bus.Address_bus = cur_addr;
        end
        if (t == s + DC) begin
            dec      = 1;
            cur_slow = ref_slow(cur_addr);
            len      = !cur_slow ? DIV : (((s / DIV) % 2) != 0 ? 3 * DIV : 2 * DIV);
        end
        if (dec && cur_slow && chg && t == s + DC + 1) bus.Address_bus = 16'h0000;
        expv = {(t == s && t > 0), (t > 0 && t % (2 * DIV) == 0),
                ((t / DIV) % 2) != 0, (dec && cur_slow && t > s + DC)};
        obs  = {bus.cpu_clk_en, bus.mhz1_en, bus.mhz1_phase, bus.slow_cycle};
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        bus.Address_bus = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            obs = {bus.cpu_clk_en, bus.mhz1_en, bus.mhz1_phase, bus.slow_cycle};
            compared++;
            if (obs !== 4'b0000) begin
                mismatched++;
                $display("FAIL reset_hold clk=%0d obs=%b exp=0000", i, obs);
            end
        end
        nRESET = 1'b1;
        t = 0; s = 0; len = DIV; dec = 0; q.delete();
        repeat (10) q.push_back(16'h1234);
        for (int i = 0; i < 64; i++) begin
            model_period();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL reset_run t=%0d obs=%b exp=%b", t, obs, expv);
            end
            tick();
        end
    endtask

    task automatic test_slow_pc0();
        do_reset();
        q = '{16'h1234, 16'h1234, 16'hFE40, 16'h1234, 16'h1234, 16'h1234};
        for (int i = 0; i < 56; i++) begin
            model_period();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL slow_pc0 t=%0d obs=%b exp=%b", t, obs, expv);
            end
            tick();
        end
    endtask

    task automatic test_slow_pc1();
        do_reset();
        q = '{16'h1234, 16'hFC00, 16'h1234, 16'h1234, 16'h1234};
        for (int i = 0; i < 56; i++) begin
            model_period();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL slow_pc1 t=%0d obs=%b exp=%b", t, obs, expv);
            end
            tick();
        end
    endtask

    task automatic test_decode_edges();
        do_reset();
        q = '{16'hFBFF, 16'hFDFF, 16'hFE20, 16'hFE1F, 16'hFE3F, 16'hFE7F,
              16'hFE80, 16'hFEC0, 16'hFEE0, 16'hFEDF, 16'h1234, 16'h1234};
        for (int i = 0; i < 240; i++) begin
            model_period();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL decode_edge t=%0d addr=%h obs=%b exp=%b", t, cur_addr, obs, expv);
            end
            tick();
        end
    endtask

    task automatic test_mid_change();
        do_reset();
        q = '{16'h1234, 32'h1FE40, 16'h1234, 16'h1234, 16'h1234};
        for (int i = 0; i < 72; i++) begin
            model_period();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL mid_change t=%0d obs=%b exp=%b", t, obs, expv);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stretch();
        bit hit;
        hit = 0;
        do_reset();
        q = '{16'h1234, 16'hFE40};
        for (int i = 0; i < 100 && !hit; i++) begin
            model_period();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL pre_abort t=%0d obs=%b exp=%b", t, obs, expv);
            end
            if (dec && cur_slow && t == s + DC + 4) hit = 1;
            else tick();
        end
        compared++;
        if (!hit) begin
            mismatched++;
            $display("FAIL abort_reach obs=no_stretch exp=stretch");
        end
        nRESET = 1'b0;
        #1;
        obs = {bus.cpu_clk_en, bus.mhz1_en, bus.mhz1_phase, bus.slow_cycle};
        compared++;
        if (obs !== 4'b0000) begin
            mismatched++;
            $display("FAIL abort_immediate obs=%b exp=0000", obs);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            obs = {bus.cpu_clk_en, bus.mhz1_en, bus.mhz1_phase, bus.slow_cycle};
            compared++;
            if (obs !== 4'b0000) begin
                mismatched++;
                $display("FAIL abort_hold clk=%0d obs=%b exp=0000", i, obs);
            end
        end
        nRESET = 1'b1;
        t = 0; s = 0; len = DIV; dec = 0; q.delete();
        repeat (8) q.push_back(16'h1234);
        for (int i = 0; i < 56; i++) begin
            model_period();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL post_abort t=%0d obs=%b exp=%b", t, obs, expv);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            model_period();
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("FAIL random t=%0d addr=%h obs=%b exp=%b", t, cur_addr, obs, expv);
            end
            tick();
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        nRESET     = 1'b0;
        bus.Address_bus = 16'h0000;
        test_reset();
        test_slow_pc0();
        test_slow_pc1();
        test_decode_edges();
        test_mid_change();
        test_reset_mid_stretch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
